// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory port arbiter.
// Holds FSM states, owner encoding and default widths.
package mem_arb_pkg;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 8;
    localparam int STREAK_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and Memory-side signals of the arbiter.
// slave = arbiter side, master = core/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W,
    parameter int DATA_W = mem_arb_pkg::DATA_W
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_write;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output if_ack, if_rdata,
        output d_ack, d_rdata,
        output mem_write, mem_read,
        output mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  if_ack, if_rdata,
        input  d_ack, d_rdata,
        input  mem_write, mem_read,
        input  mem_addr, mem_wdata,
        input  busy
    );

endinterface

// File: rtl/arb_prio_pick.sv
// Fixed D-over-IF priority with a streak limit that lets a
// waiting IF request win after MAX_STREAK back-to-back D grants.
module arb_prio_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_STREAK = 3
) (
    input  logic                if_req,
    input  logic                d_req,
    input  logic [STREAK_W-1:0] streak,
    output logic                grant,
    output owner_t              owner,
    output logic [STREAK_W-1:0] streak_nxt
);

    localparam logic [STREAK_W-1:0] MAX = STREAK_W'(MAX_STREAK);

    logic d_first;
    logic if_win;
    logic d_late;

    assign d_first = d_req && (streak < MAX);
    assign if_win  = !d_first && if_req;
    assign d_late  = !d_first && !if_req && d_req;

    always_comb begin
        grant      = 1'b0;
        owner      = OWN_D;
        streak_nxt = streak;
        unique case (1'b1)
            d_first: begin
                grant      = 1'b1;
                owner      = OWN_D;
                // streak < MAX here, so the increment saturates at MAX
                streak_nxt = if_req ? streak + 1'b1 : '0;
            end
            if_win: begin
                grant      = 1'b1;
                owner      = OWN_IF;
                streak_nxt = '0;
            end
            d_late: begin
                grant      = 1'b1;
                owner      = OWN_D;
                streak_nxt = '0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data
// access using an IDLE -> ACCESS -> RESP one-shot transaction FSM.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = mem_arb_pkg::ADDR_W,
    parameter int DATA_W     = mem_arb_pkg::DATA_W,
    parameter int MAX_STREAK = 3
) (
    input logic                clk,
    input logic                rst_n,
    mem_port_arbiter_if.slave  bus
);

    state_t              state_q;
    state_t              state_d;
    owner_t              owner_q;
    owner_t              owner_pick;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;
    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_nxt;
    logic                grant;
    logic                take;
    logic                pick_d;

    arb_prio_pick #(
        .MAX_STREAK (MAX_STREAK)
    ) u_pick (
        .if_req     (bus.if_req),
        .d_req      (bus.d_req),
        .streak     (streak_q),
        .grant      (grant),
        .owner      (owner_pick),
        .streak_nxt (streak_nxt)
    );

    assign take   = (state_q == IDLE) && grant;
    assign pick_d = (owner_pick == OWN_D);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            streak_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) streak_q <= streak_nxt;
            // IF is read-only, so its grant forces a read
            if (take) begin
                owner_q <= owner_pick;
                we_q    <= pick_d && bus.d_we;
                addr_q  <= pick_d ? bus.d_addr : bus.if_addr;
                wdata_q <= pick_d ? bus.d_wdata : '0;
            end
            if ((state_q == ACCESS) && !we_q) begin
                if (owner_q == OWN_D) d_rdata_q  <= bus.mem_rdata;
                else                  if_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_write = (state_q == ACCESS) && we_q;
    assign bus.mem_read  = (state_q == ACCESS) && !we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_ack    = (state_q == RESP) && (owner_q == OWN_IF);
    assign bus.d_ack     = (state_q == RESP) && (owner_q == OWN_D);
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = (state_q != IDLE);

endmodule
